fwd_sel: RTL
============

FWD_SEL -- requirements
Module: fwd_sel

Interface
REQ-001 SHALL have parameter N, default 5, register-specifier width.
REQ-002 SHALL have CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have RESET, input, 1, synchronous active-high reset, sampled on the rising edge of CLK.
REQ-004 SHALL have FREEZE, input, 1, global pipeline hold.
REQ-005 SHALL have FLUSH, input, 1, squashes the instruction leaving ID (taken branch).
REQ-006 SHALL have ID_RS1 and ID_RS2, input, N each, source specifiers of the instruction in ID.
REQ-007 SHALL have ID_USE1 and ID_USE2, input, 1 each, source actually read.
REQ-008 SHALL have ID_IMM, input, 1, operand B is immediate.
REQ-009 SHALL have ID_RD (input, N), ID_WE (input, 1) and ID_LOAD (input, 1): destination, write-enable and load flag of the ID instruction.
REQ-010 SHALL have SA0, SA1, SB0 and SB1, output, 1 each, registered S0/S1 selects for the EX operand A and B 4:1 muxes: 00 regfile, 01 MEM result, 10 WB result, 11 immediate (B only).
REQ-011 SHALL have HAZ, output, 1, combinational load-use stall request to the ID/IF stages.

Function
REQ-012 SHALL hold a three-slot destination pipeline EX, MEM and WB, each slot holding {rd, we, load}.
REQ-013 Each cycle, without RESET or FREEZE, SHALL advance EX->MEM->WB and load EX from ID, or with a bubble (we=0, load=0, rd=0) when HAZ or FLUSH is 1.
REQ-014 HAZ SHALL equal EX.load & EX.we & (EX.rd!=0) & ((ID_USE1 & ID_RS1==EX.rd) | (ID_USE2 & ID_RS2==EX.rd)).
REQ-015 Operand A next select SHALL be 01 if ID_USE1, EX.we, EX.rd!=0 and ID_RS1==EX.rd; else 10 if the same condition holds against MEM; else 00.
REQ-016 Operand B next select SHALL be 11 if ID_IMM; else it SHALL apply the rule of REQ-015 using ID_RS2/ID_USE2.
REQ-017 Matches against EX SHALL take priority over matches against MEM, so the newest producer wins.
REQ-018 Specifier 0 SHALL never forward.
REQ-019 Select outputs SHALL register the next-select value with 1-cycle latency, so they are valid while the instruction is in EX.
REQ-020 When a bubble is inserted (HAZ or FLUSH), SA/SB SHALL load 00.
REQ-021 When FREEZE=1, all slots and selects SHALL hold, and HAZ SHALL still be evaluated from the held state.
REQ-022 Precedence SHALL be RESET > FREEZE > FLUSH = HAZ > normal advance.
REQ-023 The WB slot SHALL only feed regfile write-through (outside this block) and SHALL NOT be compared.

Reset
REQ-024 On RESET, all slots SHALL clear to rd=0, we=0, load=0.
REQ-025 On RESET, SA0, SA1, SB0 and SB1 SHALL be 0.
REQ-026 HAZ SHALL be 0 on the cycle after reset, regardless of ID inputs.
REQ-027 A RESET mid-stall SHALL discard the pending bubble and all in-flight state.

Configuration
REQ-028 Macro FWD_WB_SRC_EN: when defined, MEM-slot matches SHALL produce select 10 per REQ-015. When undefined, select 10 SHALL never be produced, and a MEM-slot match SHALL instead assert HAZ like a load-use match (stall one cycle until regfile write-through covers it).

Verification
REQ-029 Reset, then ID {RD=3, WE=1} followed next cycle by ID {RS1=3, USE1=1} SHALL give SA1:SA0=01 one cycle later, with HAZ=0 throughout.
REQ-030 Producer rd=4, one unrelated instruction, then a consumer with RS2=4 and IMM=0 SHALL give SB=10 with the macro defined. With the macro undefined, HAZ=1 for one cycle and then SB=00.
REQ-031 Load rd=7 followed by a consumer with RS1=7 SHALL give HAZ=1 for exactly one cycle with a bubble (SA=00), then SA=10 on the retry (macro defined).
REQ-032 Two back-to-back producers both writing rd=5, then a consumer of RS1=5, SHALL give SA=01 (newest wins). A producer with rd=0 followed by a consumer of RS1=0 SHALL give SA=00.
REQ-033 FREEZE=1 for 3 cycles mid-sequence SHALL leave outputs unchanged; FLUSH=1 with a matching ID instruction SHALL leave SA=SB=00 and no later forward from the squashed rd.
REQ-034 RESET asserted while HAZ=1 SHALL give all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fwd_sel.sv
// Operand-forwarding select generator: tracks EX/MEM/WB destinations and produces registered
// EX mux selects plus a combinational load-use stall. Optional macro FWD_WB_SRC_EN enables MEM-slot forwarding.
module fwd_sel #(
    parameter int N = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         FREEZE,
    input  logic         FLUSH,
    input  logic [N-1:0] ID_RS1,
    input  logic [N-1:0] ID_RS2,
    input  logic         ID_USE1,
    input  logic         ID_USE2,
    input  logic         ID_IMM,
    input  logic [N-1:0] ID_RD,
    input  logic         ID_WE,
    input  logic         ID_LOAD,
    output logic         SA0,
    output logic         SA1,
    output logic         SB0,
    output logic         SB1,
    output logic         HAZ
);

    typedef struct packed {
        logic [N-1:0] rd;
        logic         we;
        logic         load;
    } slot_t;

    slot_t        ex_q, ex_d;
    slot_t        mem_q, mem_d;
    slot_t        wb_q, wb_d;
    logic [1:0]   sa_q, sa_d;
    logic [1:0]   sb_q, sb_d;

    logic [N-1:0] src_rs [2];
    logic [1:0]   src_use;
    logic [1:0]   match_ex;
    logic [1:0]   match_mem;
    logic [1:0]   stall_src;
    logic [1:0]   sel_next [2];
    logic         bubble;
    logic         unused_wb;

    assign src_rs[0] = ID_RS1;
    assign src_rs[1] = ID_RS2;
    assign src_use   = {ID_USE2, ID_USE1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign match_ex[gi]  = src_use[gi] & ex_q.we & (ex_q.rd != '0)
                                 & (src_rs[gi] == ex_q.rd);
            assign match_mem[gi] = src_use[gi] & mem_q.we & (mem_q.rd != '0)
                                 & (src_rs[gi] == mem_q.rd);
`ifdef FWD_WB_SRC_EN
            assign stall_src[gi] = match_ex[gi] & ex_q.load;
            assign sel_next[gi]  = match_ex[gi]  ? 2'b01 :
                                   match_mem[gi] ? 2'b10 : 2'b00;
`else
            // Without a WB path, an unshadowed MEM producer waits one cycle for regfile write-through.
            assign stall_src[gi] = (match_ex[gi] & ex_q.load) | (match_mem[gi] & ~match_ex[gi]);
            assign sel_next[gi]  = match_ex[gi] ? 2'b01 : 2'b00;
`endif
        end
    endgenerate

    assign HAZ    = |stall_src;
    assign bubble = HAZ | FLUSH;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        if (!FREEZE) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (bubble) begin
                ex_d = '0;
                sa_d = 2'b00;
                sb_d = 2'b00;
            end else begin
                ex_d = {ID_RD, ID_WE, ID_LOAD};
                sa_d = sel_next[0];
                sb_d = ID_IMM ? 2'b11 : sel_next[1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sa_q  <= 2'b00;
            sb_q  <= 2'b00;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
        end
    end

    // WB only feeds regfile write-through elsewhere; nothing here compares against it.
    assign unused_wb = ^wb_q;

    assign SA0 = sa_q[0];
    assign SA1 = sa_q[1];
    assign SB0 = sb_q[0];
    assign SB1 = sb_q[1];

endmodule
